// File: rtl/ysyx_mem_arb.sv
// Arbitrates IFU and LSU requests onto one memory port, one transaction outstanding.
// Define YSYX_ARB_RR_EN for round-robin tie-break; default build gives LSU fixed priority.
module ysyx_mem_arb #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_addr,
   output logic        ifu_resp_valid,
   output logic        ifu_resp_err,
   output logic [31:0] ifu_rdata,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic        lsu_wen,
   input  logic [7:0]  lsu_wmask,
   output logic        lsu_resp_valid,
   output logic        lsu_resp_err,
   output logic [31:0] lsu_rdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wen,
   output logic [7:0]  mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 8;
   localparam int unsigned CW = 16;
   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

   state_e        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          wen_q, wen_d;
   logic [MW-1:0] wmask_q, wmask_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
   logic          ifu_rv_q, ifu_rv_d, ifu_err_q, ifu_err_d;
   logic          lsu_rv_q, lsu_rv_d, lsu_err_q, lsu_err_d;
   logic [DW-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
   logic          lsu_win, ifu_win, done_ok, done_to;

   // Tie-break between simultaneous requesters
   always_comb begin
`ifdef YSYX_ARB_RR_EN
      lsu_win = lsu_req_valid && (!ifu_req_valid || (last_q == OWN_IFU));
`else
      lsu_win = lsu_req_valid;
`endif
      ifu_win = ifu_req_valid && !lsu_win;
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_d        = last_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wen_d         = wen_q;
      wmask_d       = wmask_q;
      cnt_d         = cnt_q;
      cnt_nxt       = cnt_q + CW'(1);
      ifu_rv_d      = 1'b0;
      ifu_err_d     = 1'b0;
      ifu_rdata_d   = ifu_rdata_q;
      lsu_rv_d      = 1'b0;
      lsu_err_d     = 1'b0;
      lsu_rdata_d   = lsu_rdata_q;
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      done_ok       = 1'b0;
      done_to       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            ifu_req_ready = ifu_win && !rst;
            lsu_req_ready = lsu_win && !rst;
            if (ifu_win || lsu_win) begin
               owner_d = lsu_win ? OWN_LSU : OWN_IFU;
               last_d  = lsu_win ? OWN_LSU : OWN_IFU;
               addr_d  = lsu_win ? lsu_addr : ifu_addr;
               wdata_d = lsu_win ? lsu_wdata : '0;
               wen_d   = lsu_win && lsu_wen;
               wmask_d = (lsu_win && lsu_wen) ? lsu_wmask : '0;
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            cnt_d = cnt_nxt;
            if (cnt_nxt == CW'(TIMEOUT_CYC)) done_to = 1'b1;
            else if (mem_req_ready)           state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_nxt;
            // A response in the timeout cycle still completes normally
            if (mem_resp_valid)                    done_ok = 1'b1;
            else if (cnt_nxt == CW'(TIMEOUT_CYC)) done_to = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (done_ok || done_to) begin
         state_d = S_IDLE;
         if (owner_q == OWN_LSU) begin
            lsu_rv_d    = 1'b1;
            lsu_err_d   = done_to;
            lsu_rdata_d = (done_ok && !wen_q) ? mem_rdata : '0;
         end else begin
            ifu_rv_d    = 1'b1;
            ifu_err_d   = done_to;
            ifu_rdata_d = done_ok ? mem_rdata : '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_IFU;
         last_q      <= OWN_IFU;
         addr_q      <= '0;
         wdata_q     <= '0;
         wen_q       <= 1'b0;
         wmask_q     <= '0;
         cnt_q       <= '0;
         ifu_rv_q    <= 1'b0;
         ifu_err_q   <= 1'b0;
         ifu_rdata_q <= '0;
         lsu_rv_q    <= 1'b0;
         lsu_err_q   <= 1'b0;
         lsu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wen_q       <= wen_d;
         wmask_q     <= wmask_d;
         cnt_q       <= cnt_d;
         ifu_rv_q    <= ifu_rv_d;
         ifu_err_q   <= ifu_err_d;
         ifu_rdata_q <= ifu_rdata_d;
         lsu_rv_q    <= lsu_rv_d;
         lsu_err_q   <= lsu_err_d;
         lsu_rdata_q <= lsu_rdata_d;
      end
   end

   assign mem_req_valid  = (state_q == S_REQ);
   assign mem_addr       = addr_q;
   assign mem_wdata      = wdata_q;
   assign mem_wen        = wen_q;
   assign mem_wmask      = wmask_q;
   assign ifu_resp_valid = ifu_rv_q;
   assign ifu_resp_err   = ifu_err_q;
   assign ifu_rdata      = ifu_rdata_q;
   assign lsu_resp_valid = lsu_rv_q;
   assign lsu_resp_err   = lsu_err_q;
   assign lsu_rdata      = lsu_rdata_q;
endmodule
